// File: rtl/hack_vga_scan_if.sv
// Scan-out bus of hack_vga_scan: screen_map read port plus the VGA pins.
// master = scan stage (drives address and video), slave = memory/monitor side.
interface hack_vga_scan_if;
    logic [12:0] scr_addr;
    logic [15:0] scr_data;
    logic        vga_hs;
    logic        vga_vs;
    logic        vga_blank_n;
    logic [3:0]  vga_r;
    logic [3:0]  vga_g;
    logic [3:0]  vga_b;

    modport master (
        output scr_addr, vga_hs, vga_vs, vga_blank_n, vga_r, vga_g, vga_b,
        input  scr_data
    );

    modport slave (
        input  scr_addr, vga_hs, vga_vs, vga_blank_n, vga_r, vga_g, vga_b,
        output scr_data
    );
endinterface

// File: rtl/hack_vga_scan.sv
// VGA scan-out of the 512x256 Hack bitmap, centred in a 640x480@60 frame.
// Optional HACK_VGA_BORDER_EN: grey surround plus a white outline ring around the window.
module hack_vga_scan #(
    parameter int CLK_DIV  = 2,
    parameter int RD_LAT   = 1,
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int X_OFS    = 64,
    parameter int Y_OFS    = 112
) (
    input  logic           clk,
    input  logic           rst_n,
    hack_vga_scan_if.master bus
);

    localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [9:0] H_LAST = 10'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
    localparam logic [9:0] H_VIS  = 10'(H_ACTIVE);
    localparam logic [9:0] HS_BEG = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] HS_END = 10'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0] V_LAST = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
    localparam logic [9:0] V_VIS  = 10'(V_ACTIVE);
    localparam logic [9:0] VS_BEG = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] VS_END = 10'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [9:0] X_BEG  = 10'(X_OFS);
    localparam logic [9:0] X_END  = 10'(X_OFS + 512);
    localparam logic [9:0] Y_BEG  = 10'(Y_OFS);
    localparam logic [9:0] Y_END  = 10'(Y_OFS + 256);

    // The word for a window cell is loaded CLK_DIV clocks after its address is issued.
    if (CLK_DIV < RD_LAT + 1) begin : g_bad_div
        $error("hack_vga_scan: CLK_DIV must be at least RD_LAT+1");
    end

    logic [DW-1:0] div;
    logic [9:0]    hcnt;
    logic [9:0]    vcnt;
    logic [15:0]   shifter;

    logic          tick;
    logic [9:0]    h_next;
    logic          in_xwin;
    logic          in_ywin;
    logic          in_win;
    logic [3:0]    hx_lo;
    logic          word_start;
    logic [8:0]    hnx;
    logic          fetch;
    logic [7:0]    vy;
    logic          pix_bit;
    logic          visible;
    logic [3:0]    colour;

    assign tick       = (div == DW'(CLK_DIV - 1));
    assign h_next     = (hcnt == H_LAST) ? 10'd0 : hcnt + 10'd1;
    assign in_xwin    = (hcnt >= X_BEG) && (hcnt < X_END);
    assign in_ywin    = (vcnt >= Y_BEG) && (vcnt < Y_END);
    assign in_win     = in_xwin && in_ywin;
    assign hx_lo      = hcnt[3:0] - X_BEG[3:0];
    assign word_start = in_win && (hx_lo == 4'd0);
    assign hnx        = h_next[8:0] - X_BEG[8:0];
    assign fetch      = in_ywin && (h_next >= X_BEG) && (h_next < X_END) && (hnx[3:0] == 4'd0);
    assign vy         = vcnt[7:0] - Y_BEG[7:0];
    assign visible    = (hcnt < H_VIS) && (vcnt < V_VIS);

    // The shifter keeps the pixels still to be shown, so the first one comes straight from the bus.
    assign pix_bit    = word_start ? bus.scr_data[0] : shifter[0];

`ifdef HACK_VGA_BORDER_EN
    localparam logic [9:0] X_RL = 10'(X_OFS - 1);
    localparam logic [9:0] X_RR = 10'(X_OFS + 512);
    localparam logic [9:0] Y_RT = 10'(Y_OFS - 1);
    localparam logic [9:0] Y_RB = 10'(Y_OFS + 256);

    logic ring;
    assign ring = (((hcnt == X_RL) || (hcnt == X_RR)) && (vcnt >= Y_RT) && (vcnt <= Y_RB))
               || (((vcnt == Y_RT) || (vcnt == Y_RB)) && (hcnt >= X_RL) && (hcnt <= X_RR));
`endif

    always_comb begin
        colour = 4'h0;
        if (in_win)
            colour = pix_bit ? 4'h0 : 4'hF;
`ifdef HACK_VGA_BORDER_EN
        else if (ring)
            colour = 4'hF;
        else
            colour = 4'h8;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div             <= '0;
            hcnt            <= '0;
            vcnt            <= '0;
            shifter         <= '0;
            bus.scr_addr    <= '0;
            bus.vga_hs      <= 1'b1;
            bus.vga_vs      <= 1'b1;
            bus.vga_blank_n <= 1'b0;
            bus.vga_r       <= '0;
            bus.vga_g       <= '0;
            bus.vga_b       <= '0;
        end else begin
            div <= tick ? '0 : div + 1'b1;
            if (tick) begin
                hcnt <= h_next;
                if (hcnt == H_LAST)
                    vcnt <= (vcnt == V_LAST) ? 10'd0 : vcnt + 10'd1;

                if (fetch)
                    bus.scr_addr <= {vy, hnx[8:4]};

                if (word_start)
                    shifter <= {1'b0, bus.scr_data[15:1]};
                else if (in_win)
                    shifter <= {1'b0, shifter[15:1]};

                bus.vga_hs      <= !((hcnt >= HS_BEG) && (hcnt < HS_END));
                bus.vga_vs      <= !((vcnt >= VS_BEG) && (vcnt < VS_END));
                bus.vga_blank_n <= visible;
                bus.vga_r       <= visible ? colour : 4'h0;
                bus.vga_g       <= visible ? colour : 4'h0;
                bus.vga_b       <= visible ? colour : 4'h0;
            end
        end
    end

endmodule

// File: tb/tb_hack_vga_scan.sv
// Directed bench for hack_vga_scan using a short vertical frame (10 lines, window from line 1)
// so that sync, fetch and pixel behaviour are all reached within a few frames.
module tb_hack_vga_scan;

    logic clk;
    logic rst_n;
    int   cyc;
    int   rel;
    int   n_cmp;
    int   n_err;

`ifdef HACK_VGA_BORDER_EN
    localparam logic [3:0] OUT_C  = 4'h8;
    localparam logic [3:0] RING_C = 4'hF;
`else
    localparam logic [3:0] OUT_C  = 4'h0;
    localparam logic [3:0] RING_C = 4'h0;
`endif

    hack_vga_scan_if bus ();

    hack_vga_scan #(
        .V_ACTIVE (4),
        .V_FP     (2),
        .V_SYNC   (2),
        .V_BP     (2),
        .Y_OFS    (1)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Registered-q screen memory: one-cycle read latency.
    always @(posedge clk) begin
        case (bus.scr_addr)
            13'd0:   bus.scr_data <= 16'h0001;
            13'd31:  bus.scr_data <= 16'h8000;
            default: bus.scr_data <= 16'h0000;
        endcase
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Land on the negedge where the outputs show pixel (x,y) of the frame started at release.
    task automatic goto_px(input int x, input int y);
        int t;
        t = 2 * (y * 800 + x + 1);
        while (cyc - rel < t) @(negedge clk);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_hs"},    32'(bus.vga_hs),      32'd1);
        check({tag, "_vs"},    32'(bus.vga_vs),      32'd1);
        check({tag, "_blank"}, 32'(bus.vga_blank_n), 32'd0);
        check({tag, "_rgb"},   {20'd0, bus.vga_r, bus.vga_g, bus.vga_b}, 32'd0);
        check({tag, "_addr"},  32'(bus.scr_addr),    32'd0);
    endtask

    initial begin
        int hs_low, hs_first, blank_hi, vs_low, vs_first;
        n_cmp = 0;
        n_err = 0;
        rst_n = 1'b0;
        rel   = 0;

        repeat (5) begin
            @(negedge clk);
            check_reset_vals("rst");
        end
        rst_n = 1'b1;
        rel   = cyc;

        // Line 0: horizontal timing and out-of-window colours.
        hs_low = 0; hs_first = -1; blank_hi = 0;
        for (int x = 0; x < 800; x++) begin
            goto_px(x, 0);
            if (!bus.vga_hs) begin
                if (hs_first < 0) hs_first = x;
                hs_low++;
            end
            if (bus.vga_blank_n) blank_hi++;
            case (x)
                0:   check("rgb_0_0",   32'(bus.vga_r), 32'(OUT_C));
                100: check("rgb_100_0", 32'(bus.vga_r), 32'(RING_C));
                640: check("rgb_640_0", 32'(bus.vga_r), 32'h0);
                default: ;
            endcase
        end
        check("hs_first", 32'(hs_first), 32'd656);
        check("hs_width", 32'(hs_low),   32'd96);
        check("blank_w",  32'(blank_hi), 32'd640);

        // Line 1: first window row, address sequence and pixel decode.
        for (int x = 0; x < 800; x++) begin
            goto_px(x, 1);
            if (x >= 63 && x <= 559 && (x - 63) % 16 == 0)
                check("addr_seq", 32'(bus.scr_addr), 32'((x - 63) / 16));
            case (x)
                63:  check("rgb_63_1",  32'(bus.vga_r), 32'(RING_C));
                64:  check("rgb_64_1",  32'(bus.vga_r), 32'h0);
                65: begin
                    check("rgb_65_1", 32'(bus.vga_r), 32'hF);
                    check("rgb_eq",   {24'd0, bus.vga_g, bus.vga_b}, 32'hFF);
                end
                574: check("rgb_574_1", 32'(bus.vga_r), 32'hF);
                575: check("rgb_575_1", 32'(bus.vga_r), 32'h0);
                576: check("rgb_576_1", 32'(bus.vga_r), 32'(RING_C));
                639: check("rgb_639_1", 32'(bus.vga_r), 32'(OUT_C));
                700: check("addr_hold", 32'(bus.scr_addr), 32'd31);
                default: ;
            endcase
        end
        goto_px(63, 2);
        check("addr_row1", 32'(bus.scr_addr), 32'd32);
        goto_px(64, 2);
        check("rgb_64_2", 32'(bus.vga_r), 32'hF);

        // Vertical sync over the 10-line frame.
        vs_low = 0; vs_first = -1;
        for (int v = 2; v < 10; v++) begin
            goto_px(100, v);
            if (!bus.vga_vs) begin
                if (vs_first < 0) vs_first = v;
                vs_low++;
            end
        end
        check("vs_first", 32'(vs_first), 32'd6);
        check("vs_lines", 32'(vs_low),   32'd2);
        goto_px(100, 10);
        check("vs_wrap", 32'(bus.vga_vs), 32'd1);
        goto_px(62, 11);
        check("addr_last", 32'(bus.scr_addr), 32'd287);
        goto_px(63, 11);
        check("addr_frame2", 32'(bus.scr_addr), 32'd0);
        goto_px(100, 16);
        check("vs_frame2", 32'(bus.vga_vs), 32'd0);
        goto_px(100, 18);
        check("vs_frame2_end", 32'(bus.vga_vs), 32'd1);

        // Mid-line reset: outputs drop at once, timing restarts from release.
        goto_px(300, 22);
        rst_n = 1'b0;
        #1;
        check_reset_vals("midrst");
        @(negedge clk);
        rst_n = 1'b1;
        rel   = cyc;
        goto_px(100, 5);
        check("vs_after_rst_pre", 32'(bus.vga_vs), 32'd1);
        goto_px(100, 6);
        check("vs_after_rst", 32'(bus.vga_vs), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
